// File: rtl/control_unit.sv
// control_unit: multi-cycle hardwired sequencer issuing one datapath control word per clock.
module control_unit #(
  parameter int IR_WIDTH = 32,
  parameter int STEP_W = 3
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [IR_WIDTH-1:0] IR,
  input  logic                CON,
  input  logic                stop,
  output logic                run,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                Read,
  output logic                Write,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                HIout,
  output logic                LOin,
  output logic                LOout,
  output logic                InPortout,
  output logic                outPortin,
  output logic                Cout,
  output logic                conIn,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rin,
  output logic                Rout,
  output logic                BAout,
  output logic                AND,
  output logic                OR,
  output logic                NEG,
  output logic                NOT,
  output logic                SUB,
  output logic                ADD,
  output logic                MUL,
  output logic                DIV,
  output logic                SHL,
  output logic                SHR,
  output logic                SHRA,
  output logic                ROR,
  output logic                ROL
);
  typedef enum logic [1:0] {RESET, EXEC, HALT} mode_e;
  mode_e              mode_q;
  logic [STEP_W-1:0]  step_q;
  logic               stop_q;
  logic [4:0]         op;
  logic               unused_ir;
  logic               alu3, imm, ld, ldi, st, ldst, md, nn, br, jr, jal, inp, outp, mfhi, mflo, hlt;
  logic [STEP_W-1:0]  last;
  logic               fin, act, op_en;
  assign op = IR[IR_WIDTH-1 -: 5];
  assign unused_ir = ^IR[IR_WIDTH-6:0];
  assign alu3 = op >= 5'd3 && op <= 5'd11;
  assign imm  = op >= 5'd12 && op <= 5'd14;
  assign ld   = op == 5'd0;
  assign ldi  = op == 5'd1;
  assign st   = op == 5'd2;
  assign ldst = ld | ldi | st;
  assign md   = op == 5'd15 || op == 5'd16;
  assign nn   = op == 5'd17 || op == 5'd18;
  assign br   = op == 5'd19;
  assign jr   = op == 5'd20;
  assign jal  = op == 5'd21;
  assign inp  = op == 5'd22;
  assign outp = op == 5'd23;
  assign mfhi = op == 5'd24;
  assign mflo = op == 5'd25;
  assign hlt  = op == 5'd27;
  // Final step of the execute sequence; fetch steps are always below it.
  assign last = (ld | st) ? STEP_W'(7) : (md | br) ? STEP_W'(6) :
                (alu3 | imm | ldi) ? STEP_W'(5) : (nn | jal) ? STEP_W'(4) : STEP_W'(3);
  assign fin = step_q == last;
  assign act = !clr && mode_q == EXEC;
  assign run = act;
  always_ff @(posedge clk) begin
    if (clr) begin
      mode_q <= RESET;
      step_q <= '0;
      stop_q <= 1'b0;
    end else begin
      case (mode_q)
        RESET: begin
          mode_q <= EXEC;
          step_q <= '0;
        end
        EXEC: begin
          if (fin) begin
            step_q <= '0;
            stop_q <= 1'b0;
            if (hlt || stop_q || stop) mode_q <= HALT;
          end else begin
            step_q <= step_q + 1'b1;
            stop_q <= stop_q | stop;
          end
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin} = '0;
    {Zlowout, Zhighout, HIin, HIout, LOin, LOout, InPortout, outPortin, Cout, conIn} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    op_en = 1'b0;
    if (act) begin
      case (step_q)
        STEP_W'(0): begin
          PCout = 1'b1;
          MARin = 1'b1;
          IncPC = 1'b1;
          Zin   = 1'b1;
        end
        STEP_W'(1): begin
          Zlowout = 1'b1;
          PCin    = 1'b1;
          Read    = 1'b1;
          MDRin   = 1'b1;
        end
        STEP_W'(2): begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        STEP_W'(3): begin
          Grb       = alu3 | imm | ldst | nn | jal;
          Gra       = md | br | jr | inp | outp | mfhi | mflo;
          Rout      = alu3 | imm | md | nn | br | jr | outp;
          Yin       = alu3 | imm | ldst | md;
          BAout     = ldst;
          op_en     = nn;
          Zin       = nn;
          conIn     = br;
          PCin      = jr;
          PCout     = jal;
          Rin       = jal | inp | mfhi | mflo;
          InPortout = inp;
          outPortin = outp;
          HIout     = mfhi;
          LOout     = mflo;
        end
        STEP_W'(4): begin
          Grc     = alu3;
          Grb     = md;
          Rout    = alu3 | md | jal;
          Cout    = imm | ldst;
          op_en   = alu3 | imm | ldst | md;
          Zin     = alu3 | imm | ldst | md;
          Zlowout = nn;
          Gra     = nn | jal;
          Rin     = nn;
          PCout   = br;
          Yin     = br;
          PCin    = jal;
        end
        STEP_W'(5): begin
          Zlowout = alu3 | imm | ldst | md;
          Gra     = alu3 | imm | ldi;
          Rin     = alu3 | imm | ldi;
          MARin   = ld | st;
          LOin    = md;
          Cout    = br;
          op_en   = br;
          Zin     = br;
        end
        STEP_W'(6): begin
          Read     = ld;
          MDRin    = ld | st;
          Gra      = st;
          Rout     = st;
          Zhighout = md;
          HIin     = md;
          Zlowout  = br & CON;
          PCin     = br & CON;
        end
        STEP_W'(7): begin
          MDRout = ld;
          Gra    = ld;
          Rin    = ld;
          Write  = st;
        end
        default: ;
      endcase
    end
  end
  // Address arithmetic (ld/ldi/st) and branch targets use the adder.
  assign ADD  = op_en & (ldst | br | op == 5'd3 | op == 5'd12);
  assign SUB  = op_en & (op == 5'd4);
  assign AND  = op_en & (op == 5'd5 | op == 5'd13);
  assign OR   = op_en & (op == 5'd6 | op == 5'd14);
  assign SHR  = op_en & (op == 5'd7);
  assign SHRA = op_en & (op == 5'd8);
  assign SHL  = op_en & (op == 5'd9);
  assign ROR  = op_en & (op == 5'd10);
  assign ROL  = op_en & (op == 5'd11);
  assign MUL  = op_en & (op == 5'd15);
  assign DIV  = op_en & (op == 5'd16);
  assign NEG  = op_en & (op == 5'd17);
  assign NOT  = op_en & (op == 5'd18);
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and random instruction streams against a per-instruction step-table model.
module tb_control_unit;
  logic clk = 1'b0;
  logic clr = 1'b1, CON = 1'b0, stop = 1'b0;
  logic [31:0] IR = '0;
  logic run, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin;
  logic Zlowout, Zhighout, HIin, HIout, LOin, LOout, InPortout, outPortin, Cout, conIn;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic AND, OR, NEG, NOT, SUB, ADD, MUL, DIV, SHL, SHR, SHRA, ROR, ROL;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  control_unit dut (
    .clk(clk), .clr(clr), .IR(IR), .CON(CON), .stop(stop), .run(run),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
    .InPortout(InPortout), .outPortin(outPortin), .Cout(Cout), .conIn(conIn),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .AND(AND), .OR(OR), .NEG(NEG), .NOT(NOT), .SUB(SUB), .ADD(ADD), .MUL(MUL), .DIV(DIV),
    .SHL(SHL), .SHR(SHR), .SHRA(SHRA), .ROR(ROR), .ROL(ROL)
  );
  localparam int B_PCOUT = 0, B_PCIN = 1, B_INCPC = 2, B_MARIN = 3, B_MDRIN = 4, B_MDROUT = 5;
  localparam int B_READ = 6, B_WRITE = 7, B_IRIN = 8, B_YIN = 9, B_ZIN = 10, B_ZLO = 11;
  localparam int B_ZHI = 12, B_HIIN = 13, B_HIOUT = 14, B_LOIN = 15, B_LOOUT = 16, B_INP = 17;
  localparam int B_OUTP = 18, B_COUT = 19, B_CONIN = 20, B_GRA = 21, B_GRB = 22, B_GRC = 23;
  localparam int B_RIN = 24, B_ROUT = 25, B_BAOUT = 26, B_AND = 27, B_OR = 28, B_NEG = 29;
  localparam int B_NOT = 30, B_SUB = 31, B_ADD = 32, B_MUL = 33, B_DIV = 34, B_SHL = 35;
  localparam int B_SHR = 36, B_SHRA = 37, B_ROR = 38, B_ROL = 39;
  wire [39:0] obs = {ROL, ROR, SHRA, SHR, SHL, DIV, MUL, ADD, SUB, NOT, NEG, OR, AND,
                     BAout, Rout, Rin, Grc, Grb, Gra, conIn, Cout, outPortin, InPortout,
                     LOout, LOin, HIout, HIin, Zhighout, Zlowout, Zin, Yin, IRin, Write, Read,
                     MDRout, MDRin, MARin, IncPC, PCin, PCout};
  function automatic logic [39:0] m(input int a = -1, input int b = -1, input int c = -1, input int d = -1);
    logic [39:0] v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    return v;
  endfunction
  function automatic int alu_of(input logic [4:0] op);
    case (op)
      5'd4: return B_SUB;
      5'd5, 5'd13: return B_AND;
      5'd6, 5'd14: return B_OR;
      5'd7: return B_SHR;
      5'd8: return B_SHRA;
      5'd9: return B_SHL;
      5'd10: return B_ROR;
      5'd11: return B_ROL;
      5'd15: return B_MUL;
      5'd16: return B_DIV;
      5'd17: return B_NEG;
      5'd18: return B_NOT;
      default: return B_ADD;
    endcase
  endfunction
  // Whole control-word table for one instruction; n is its length in cycles including fetch.
  function automatic logic [39:0] expected(input logic [4:0] op, input int t, input logic con, output int n);
    logic [39:0] s [8];
    int a;
    a = alu_of(op);
    for (int i = 0; i < 8; i++) s[i] = '0;
    s[0] = m(B_PCOUT, B_MARIN, B_INCPC, B_ZIN);
    s[1] = m(B_ZLO, B_PCIN, B_READ, B_MDRIN);
    s[2] = m(B_MDROUT, B_IRIN);
    n = 4;
    if (op >= 3 && op <= 11) begin
      n = 6; s[3] = m(B_GRB, B_ROUT, B_YIN); s[4] = m(B_GRC, B_ROUT, a, B_ZIN); s[5] = m(B_ZLO, B_GRA, B_RIN);
    end else if (op >= 12 && op <= 14) begin
      n = 6; s[3] = m(B_GRB, B_ROUT, B_YIN); s[4] = m(B_COUT, a, B_ZIN); s[5] = m(B_ZLO, B_GRA, B_RIN);
    end else if (op <= 2) begin
      s[3] = m(B_GRB, B_BAOUT, B_YIN); s[4] = m(B_COUT, B_ADD, B_ZIN);
      if (op == 1) begin
        n = 6; s[5] = m(B_ZLO, B_GRA, B_RIN);
      end else begin
        n = 8; s[5] = m(B_ZLO, B_MARIN);
        s[6] = (op == 0) ? m(B_READ, B_MDRIN) : m(B_GRA, B_ROUT, B_MDRIN);
        s[7] = (op == 0) ? m(B_MDROUT, B_GRA, B_RIN) : m(B_WRITE);
      end
    end else if (op == 15 || op == 16) begin
      n = 7; s[3] = m(B_GRA, B_ROUT, B_YIN); s[4] = m(B_GRB, B_ROUT, a, B_ZIN);
      s[5] = m(B_ZLO, B_LOIN); s[6] = m(B_ZHI, B_HIIN);
    end else if (op == 17 || op == 18) begin
      n = 5; s[3] = m(B_GRB, B_ROUT, a, B_ZIN); s[4] = m(B_ZLO, B_GRA, B_RIN);
    end else if (op == 19) begin
      n = 7; s[3] = m(B_GRA, B_ROUT, B_CONIN); s[4] = m(B_PCOUT, B_YIN); s[5] = m(B_COUT, B_ADD, B_ZIN);
      s[6] = con ? m(B_ZLO, B_PCIN) : '0;
    end else if (op == 20) s[3] = m(B_GRA, B_ROUT, B_PCIN);
    else if (op == 21) begin
      n = 5; s[3] = m(B_PCOUT, B_GRB, B_RIN); s[4] = m(B_GRA, B_ROUT, B_PCIN);
    end
    else if (op == 22) s[3] = m(B_INP, B_GRA, B_RIN);
    else if (op == 23) s[3] = m(B_GRA, B_ROUT, B_OUTP);
    else if (op == 24) s[3] = m(B_HIOUT, B_GRA, B_RIN);
    else if (op == 25) s[3] = m(B_LOOUT, B_GRA, B_RIN);
    return s[t & 7];
  endfunction
  task automatic cycle(input logic c, input logic [31:0] ir, input logic con, input logic stp,
                       input logic [40:0] exp, input string tag);
    @(negedge clk);
    clr = c; IR = ir; CON = con; stop = stp;
    #1;
    vectors++;
    assert ({run, obs} === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, {run, obs}, exp);
    end
  endtask
  task automatic restart(input int k);
    for (int i = 0; i < k; i++) cycle(1'b1, IR, 1'b0, 1'b0, '0, "clr_active");
    cycle(1'b0, IR, 1'b0, 1'b0, '0, "reset_mode");
  endtask
  task automatic idle(input int k);
    logic [31:0] r;
    for (int i = 0; i < k; i++) begin
      r = $urandom();
      cycle(1'b0, r, r[0], 1'b0, '0, "halt_idle");
    end
  endtask
  task automatic exec_instr(input logic [31:0] ir, input logic con, input int stop_t, output bit halted);
    int n;
    logic [39:0] e;
    e = expected(ir[31:27], 0, con, n);
    for (int t = 0; t < n; t++) begin
      e = expected(ir[31:27], t, con, n);
      cycle(1'b0, ir, con, t == stop_t, {1'b1, e}, $sformatf("op%0d_T%0d", ir[31:27], t));
    end
    halted = (stop_t >= 0 && stop_t < n) || ir[31:27] == 5'd27;
  endtask
  initial begin
    bit h;
    int n, st;
    logic [31:0] r, ir;
    logic [39:0] e;
    restart(2);
    exec_instr(32'h19890000, 1'b0, -1, h);
    exec_instr(32'h00800055, 1'b0, -1, h);
    exec_instr(32'h98000000, 1'b0, -1, h);
    exec_instr(32'h98000000, 1'b1, -1, h);
    exec_instr(32'h10000000, 1'b1, -1, h);
    exec_instr(32'h00800055, 1'b0, 4, h);
    idle(5);
    restart(1);
    exec_instr(32'hD8000000, 1'b0, -1, h);
    idle(20);
    restart(1);
    for (int t = 0; t < 5; t++) begin
      e = expected(5'd3, t, 1'b0, n);
      cycle(1'b0, 32'h19890000, 1'b0, 1'b0, {1'b1, e}, "add_before_clr");
    end
    cycle(1'b1, 32'h19890000, 1'b0, 1'b0, '0, "clr_mid_T5");
    cycle(1'b0, 32'h19890000, 1'b0, 1'b0, '0, "reset_after_clr");
    exec_instr(32'h19890000, 1'b0, -1, h);
    for (int i = 0; i < 80; i++) begin
      r = $urandom();
      ir = {5'($urandom_range(0, 31)), r[26:0]};
      st = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      exec_instr(ir, 1'($urandom_range(0, 1)), st, h);
      if (h) begin
        idle(3);
        restart(1);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
